alu_share_arb: RTL and testbench



---
 rtl/alu_share_arb_pkg.sv | 25 ++
 rtl/alu_share_arb_if.sv | 32 +++
 rtl/alu_share_arb_rr_grant.sv | 40 ++++
 rtl/alu_share_arb.sv | 109 ++++++++++
 tb/tb_alu_share_arb.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared encodings for the ALU sharing arbiter: FSM states, bus widths, ALU select codes.
package alu_share_arb_pkg;

  localparam int ARB_NREQ  = 2;
  localparam int REG_BUS_W = 32;
  localparam int ALUSEL_W  = 4;

  localparam logic [ALUSEL_W-1:0] ALUSEL_ADD  = 4'd0;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SUB  = 4'd1;
  localparam logic [ALUSEL_W-1:0] ALUSEL_AND  = 4'd2;
  localparam logic [ALUSEL_W-1:0] ALUSEL_OR   = 4'd3;
  localparam logic [ALUSEL_W-1:0] ALUSEL_XOR  = 4'd4;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLT  = 4'd5;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLTU = 4'd6;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SLL  = 4'd7;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SRL  = 4'd8;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_RESP  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester, response and ALU-side signals of the ALU sharing arbiter.
interface alu_share_arb_if #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 4
);
   logic [NREQ-1:0]        req_valid_i;
   logic [NREQ-1:0]        req_ready_o;
   logic [NREQ*DATA_W-1:0] req_a_i;
   logic [NREQ*DATA_W-1:0] req_b_i;
   logic [NREQ*SEL_W-1:0]  req_sel_i;
   logic [NREQ-1:0]        rsp_valid_o;
   logic [NREQ-1:0]        rsp_ready_i;
   logic [DATA_W-1:0]      rsp_data_o;
   logic [DATA_W-1:0]      alu_a_o;
   logic [DATA_W-1:0]      alu_b_o;
   logic [SEL_W-1:0]       alu_sel_o;
   logic [DATA_W-1:0]      alu_res_i;
   logic                   busy_o;

   // The arbiter itself.
   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_sel_i, rsp_ready_i, alu_res_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, alu_a_o, alu_b_o, alu_sel_o, busy_o
   );

   // The parent: requesters plus the shared ALU.
   modport master (
      output req_valid_i, req_a_i, req_b_i, req_sel_i, rsp_ready_i, alu_res_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, alu_a_o, alu_b_o, alu_sel_o, busy_o
   );
endinterface

// File: rtl/alu_share_arb_rr_grant.sv
// Combinational NREQ-wide priority pick starting at ptr and wrapping.
// ALU_ARB_FIXED_PRIO_EN: ignore ptr and always favour the lowest index.
module rr_grant #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt_onehot,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             any
);
   int cand;

   assign any = |valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      gnt_onehot = '0;
      gnt_idx    = '0;
      cand       = 0;
      // Scan from lowest to highest priority so the last hit is the winner.
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         cand = k;
`else
         cand = (int'(ptr) + k) % NREQ;
`endif
         if (valid[cand]) begin
            gnt_onehot = NREQ'(1) << cand;
            gnt_idx    = PTR_W'(cand);
         end
      end
   end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters: arbitrate, issue, return result.
// ALU_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int NREQ   = ARB_NREQ,
   parameter int DATA_W = REG_BUS_W,
   parameter int SEL_W  = ALUSEL_W
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   alu_share_arb_if.slave bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e        state;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  grant_q;
   logic [PTR_W-1:0]  gnt_idx;
   logic [NREQ-1:0]   gnt_onehot;
   logic [NREQ-1:0]   rsp_valid_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] result_q;
   logic [SEL_W-1:0]  sel_q;
   logic              busy_q;
   logic              any_valid;
   logic              rsp_done;
   logic              accept;

   rr_grant #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_grant (
      .valid      (bus.req_valid_i),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any_valid)
   );

   // Only the granted requester's rsp_ready can complete a response.
   assign rsp_done = (state == ARB_RESP) && bus.rsp_ready_i[grant_q];
   assign accept   = any_valid && ((state == ARB_IDLE) || rsp_done);

   assign bus.req_ready_o = accept ? gnt_onehot : '0;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = result_q;
   assign bus.alu_a_o     = a_q;
   assign bus.alu_b_o     = b_q;
   assign bus.alu_sel_o   = sel_q;
   assign bus.busy_o      = busy_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: the datapath registers are reset too, so the ALU inputs read 0 after reset.
      if (!rst_n_i) begin
         state       <= ARB_IDLE;
         grant_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         result_q    <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: ;
            ARB_ISSUE: begin
               result_q    <= bus.alu_res_i;
               rsp_valid_q <= NREQ'(1) << grant_q;
               state       <= ARB_RESP;
            end
            ARB_RESP: begin
               if (rsp_done) begin
                  rsp_valid_q <= '0;
                  state       <= ARB_IDLE;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               busy_q <= 1'b0;
            end
         endcase
         // NOTE: placed after the case so an accept overrides the IDLE return above;
         // with non-blocking assignments the last write in the block wins.
         if (accept) begin
            a_q     <= bus.req_a_i[gnt_idx*DATA_W +: DATA_W];
            b_q     <= bus.req_b_i[gnt_idx*DATA_W +: DATA_W];
            sel_q   <= bus.req_sel_i[gnt_idx*SEL_W +: SEL_W];
            grant_q <= gnt_idx;
            state   <= ARB_ISSUE;
            busy_q  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a behavioural ALU attached.
module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   checks = 0;
   int   failures = 0;

   alu_share_arb_if #(.NREQ(2), .DATA_W(32), .SEL_W(4)) bus ();

   alu_share_arb #(.NREQ(2), .DATA_W(32), .SEL_W(4)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] sel);
      case (sel)
         ALUSEL_ADD:  return a + b;
         ALUSEL_SUB:  return a - b;
         ALUSEL_AND:  return a & b;
         ALUSEL_OR:   return a | b;
         ALUSEL_XOR:  return a ^ b;
         ALUSEL_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALUSEL_SLTU: return {31'd0, a < b};
         default:     return 32'd0;
      endcase
   endfunction

   always_comb bus.alu_res_i = alu_model(bus.alu_a_o, bus.alu_b_o, bus.alu_sel_o);

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel);
      bus.req_a_i[idx*32 +: 32] = a;
      bus.req_b_i[idx*32 +: 32] = b;
      bus.req_sel_i[idx*4 +: 4] = sel;
   endtask

   task automatic do_reset();
      rst_n_i         = 1'b0;
      bus.req_valid_i = 2'b00;
      bus.rsp_ready_i = 2'b00;
      bus.req_a_i     = '0;
      bus.req_b_i     = '0;
      bus.req_sel_i   = '0;
      repeat (2) tick();
      rst_n_i = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      bus.req_valid_i = 2'b11;
      bus.rsp_ready_i = 2'b11;
      set_req(0, 32'd1, 32'd2, ALUSEL_ADD);
      set_req(1, 32'd3, 32'd4, ALUSEL_ADD);
      tick();
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
      checks++; if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
      checks++; if (bus.alu_a_o !== 32'd0 || bus.alu_b_o !== 32'd0 || bus.alu_sel_o !== 4'd0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", bus.alu_a_o, bus.alu_b_o, bus.alu_sel_o); end
      checks++; if (bus.rsp_data_o !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data_o); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      bus.rsp_ready_i = 2'b11;
      set_req(0, 32'd5, 32'd7, ALUSEL_ADD);
      bus.req_valid_i = 2'b01;
      #1;
      checks++; if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL single_accept got=%b exp=01", bus.req_ready_o); end
      tick();
      bus.req_valid_i = 2'b00;
      #1;
      checks++; if (bus.busy_o !== 1'b1 || bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL single_issue busy=%b rsp_valid=%b exp=1/00", bus.busy_o, bus.rsp_valid_o); end
      checks++; if (bus.alu_a_o !== 32'd5 || bus.alu_b_o !== 32'd7 || bus.alu_sel_o !== ALUSEL_ADD) begin failures++; $display("FAIL single_alu_in got=%0d/%0d/%0d exp=5/7/0", bus.alu_a_o, bus.alu_b_o, bus.alu_sel_o); end
      tick();
      checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 32'd12) begin failures++; $display("FAIL single_resp valid=%b data=%0d exp=01/12", bus.rsp_valid_o, bus.rsp_data_o); end
      tick();
      checks++; if (bus.busy_o !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL single_idle busy=%b rsp_valid=%b exp=0/00", bus.busy_o, bus.rsp_valid_o); end
      checks++; if (bus.alu_a_o !== 32'd5) begin failures++; $display("FAIL single_alu_hold got=%0d exp=5", bus.alu_a_o); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  eg;
      logic [31:0] ed;
      do_reset();
      bus.rsp_ready_i = 2'b11;
      set_req(0, 32'hFFFF_FFFF, 32'd1, ALUSEL_SLT);
      set_req(1, 32'd10, 32'd3, ALUSEL_SUB);
      bus.req_valid_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         eg = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
         ed = (eg == 2'b01) ? 32'd1 : 32'd7;
         #1;
         checks++; if (bus.req_ready_o !== eg) begin failures++; $display("FAIL rr_grant op%0d got=%b exp=%b", i, bus.req_ready_o, eg); end
         tick();
         if (i == 3) bus.req_valid_i = 2'b00;
         #1;
         checks++; if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rr_issue op%0d ready=%b rsp_valid=%b exp=00/00", i, bus.req_ready_o, bus.rsp_valid_o); end
         tick();
         checks++; if (bus.rsp_valid_o !== eg || bus.rsp_data_o !== ed) begin failures++; $display("FAIL rr_resp op%0d valid=%b data=%0d exp=%b/%0d", i, bus.rsp_valid_o, bus.rsp_data_o, eg, ed); end
      end
      tick();
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rr_idle busy got=%b exp=0", bus.busy_o); end
      // req1 alone is served when req0 is not requesting.
      bus.req_valid_i = 2'b10;
      #1;
      checks++; if (bus.req_ready_o !== 2'b10) begin failures++; $display("FAIL rr_solo_req1 got=%b exp=10", bus.req_ready_o); end
      tick();
      bus.req_valid_i = 2'b00;
      tick();
      checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== 32'd7) begin failures++; $display("FAIL rr_solo_resp valid=%b data=%0d exp=10/7", bus.rsp_valid_o, bus.rsp_data_o); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.rsp_ready_i = 2'b01;
      set_req(1, 32'hFFFF_FFFF, 32'd1, ALUSEL_SLTU);
      set_req(0, 32'd5, 32'd7, ALUSEL_ADD);
      bus.req_valid_i = 2'b10;
      #1;
      checks++; if (bus.req_ready_o !== 2'b10) begin failures++; $display("FAIL bp_accept got=%b exp=10", bus.req_ready_o); end
      tick();
      bus.req_valid_i = 2'b01;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== 32'd0) begin failures++; $display("FAIL bp_hold cyc%0d valid=%b data=%0d exp=10/0", i, bus.rsp_valid_o, bus.rsp_data_o); end
         checks++; if (bus.req_ready_o !== 2'b00 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL bp_block cyc%0d ready=%b busy=%b exp=00/1", i, bus.req_ready_o, bus.busy_o); end
         tick();
      end
      bus.rsp_ready_i = 2'b11;
      #1;
      checks++; if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL bp_release_accept got=%b exp=01", bus.req_ready_o); end
      tick();
      bus.req_valid_i = 2'b00;
      #1;
      checks++; if (bus.rsp_valid_o !== 2'b00 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL bp_next_issue valid=%b busy=%b exp=00/1", bus.rsp_valid_o, bus.busy_o); end
      tick();
      checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 32'd12) begin failures++; $display("FAIL bp_next_resp valid=%b data=%0d exp=01/12", bus.rsp_valid_o, bus.rsp_data_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [4] = '{32'hF0F0_F0F0, 32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF};
      logic [31:0] vb [4] = '{32'h0FF0_0FF0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      logic [31:0] ve [4] = '{32'hFF00_FF00, 32'hEDCB_A987, 32'hA5A5_A5A5, 32'h0000_0000};
      do_reset();
      bus.rsp_ready_i = 2'b01;
      bus.req_valid_i = 2'b01;
      for (int i = 0; i < 4; i++) begin
         set_req(0, va[i], vb[i], ALUSEL_XOR);
         #1;
         checks++; if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL b2b_accept op%0d got=%b exp=01", i, bus.req_ready_o); end
         tick();
         if (i == 3) bus.req_valid_i = 2'b00;
         #1;
         checks++; if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL b2b_gap op%0d got=%b exp=00", i, bus.rsp_valid_o); end
         tick();
         checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== ve[i]) begin failures++; $display("FAIL b2b_resp op%0d valid=%b data=%h exp=01/%h", i, bus.rsp_valid_o, bus.rsp_data_o, ve[i]); end
      end
      tick();
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle busy got=%b exp=0", bus.busy_o); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      bus.rsp_ready_i = 2'b11;
      set_req(0, 32'd5, 32'd7, ALUSEL_ADD);
      set_req(1, 32'd10, 32'd3, ALUSEL_SUB);
      bus.req_valid_i = 2'b01;
      tick();
      bus.req_valid_i = 2'b00;
      #1;
      checks++; if (bus.busy_o !== 1'b1 || bus.alu_a_o !== 32'd5) begin failures++; $display("FAIL midrst_pre busy=%b alu_a=%0d exp=1/5", bus.busy_o, bus.alu_a_o); end
      rst_n_i = 1'b0;
      #1;
      checks++; if (bus.rsp_valid_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.alu_a_o !== 32'd0) begin failures++; $display("FAIL midrst_async valid=%b busy=%b alu_a=%0d exp=00/0/0", bus.rsp_valid_o, bus.busy_o, bus.alu_a_o); end
      tick();
      checks++; if (bus.rsp_valid_o !== 2'b00 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_held valid=%b busy=%b exp=00/0", bus.rsp_valid_o, bus.busy_o); end
      rst_n_i = 1'b1;
      bus.req_valid_i = 2'b11;
      #1;
      checks++; if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL midrst_ptr got=%b exp=01", bus.req_ready_o); end
      tick();
      bus.req_valid_i = 2'b00;
      tick();
      checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 32'd12) begin failures++; $display("FAIL midrst_resp valid=%b data=%0d exp=01/12", bus.rsp_valid_o, bus.rsp_data_o); end
      tick();
   endtask

   initial begin
      bus.req_valid_i = 2'b00;
      bus.rsp_ready_i = 2'b00;
      bus.req_a_i     = '0;
      bus.req_b_i     = '0;
      bus.req_sel_i   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
